// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised synchronous RAM and its clear sequencer.
package ram_pkg;

  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_e;

  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

  function automatic int unsigned lane_count(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, issuing an all-zero write per cycle.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam int unsigned CntWidth = ADDR_WIDTH + 1;
  localparam logic [CntWidth-1:0] LastAddr = {1'b0, {ADDR_WIDTH{1'b1}}};

  ram_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) state_q <= RAM_CLEAR;
      else                     state_q <= RAM_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      RAM_IDLE: ;
      RAM_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // The last word is written on this same cycle; busy drops on the next.
        if (cnt_q == LastAddr) state_d = RAM_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == RAM_CLEAR);
  assign clr_addr = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with byte enables, registered valid-flagged
// reads, selectable read-during-write behaviour and an optional post-reset clear.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned READ_MODE      = READ_FIRST,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeOn,
  input  logic                    readOn,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    dataValid,
  output logic                    busy
);

  localparam int unsigned Lanes = lane_count(DATA_WIDTH);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  port_we, port_re;
  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_word;

  ram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign port_we  = writeOn & ~busy;
  assign port_re  = readOn & ~busy;
  assign old_word = mem[address];

  always_comb begin
    merged_word = old_word;
    for (int unsigned k = 0; k < Lanes; k++) begin
      if (byteEn[k]) merged_word[8*k +: 8] = data_in[8*k +: 8];
    end
  end

  // Write-first forwards the merged word; read-first returns the array word before the edge.
  assign rd_word = (READ_MODE == WRITE_FIRST && port_we) ? merged_word : old_word;

  // The array has no reset; clearing is done by the sequencer through the write port.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (port_we) begin
      for (int unsigned k = 0; k < Lanes; k++) begin
        if (byteEn[k]) mem[address][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      dataValid <= 1'b0;
    end else begin
      dataValid <= port_re;
      if (port_re) data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboard bench: read-first, write-first and no-clear instances of ram_sync_param.
module tb_ram_sync_param;

  logic        clk;
  logic        reset, reset2;
  logic        writeOn, readOn, we2, re2;
  logic [4:0]  address, addr2;
  logic [3:0]  byteEn, be2;
  logic [31:0] data_in, din2;
  logic [31:0] dout_rf, dout_wf, dout_nc;
  logic        dv_rf, dv_wf, dv_nc;
  logic        busy_rf, busy_wf, busy_nc;

  logic [31:0] q_rf[$], q_wf[$], q_nc[$];
  int n_checks = 0;
  int n_errors = 0;

  ram_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_MODE(0), .CLEAR_ON_RESET(1)) dut_rf (
    .clk(clk), .reset(reset), .writeOn(writeOn), .readOn(readOn), .address(address),
    .byteEn(byteEn), .data_in(data_in), .data_out(dout_rf), .dataValid(dv_rf), .busy(busy_rf)
  );

  ram_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_MODE(1), .CLEAR_ON_RESET(1)) dut_wf (
    .clk(clk), .reset(reset), .writeOn(writeOn), .readOn(readOn), .address(address),
    .byteEn(byteEn), .data_in(data_in), .data_out(dout_wf), .dataValid(dv_wf), .busy(busy_wf)
  );

  ram_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_MODE(0), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset(reset2), .writeOn(we2), .readOn(re2), .address(addr2),
    .byteEn(be2), .data_in(din2), .data_out(dout_nc), .dataValid(dv_nc), .busy(busy_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && dv_rf === 1'b1) begin
      if (q_rf.size() == 0) check("rf_unexpected_valid", 32'd1, 32'd0);
      else check("rf_read", dout_rf, q_rf.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && dv_wf === 1'b1) begin
      if (q_wf.size() == 0) check("wf_unexpected_valid", 32'd1, 32'd0);
      else check("wf_read", dout_wf, q_wf.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset2 && dv_nc === 1'b1) begin
      if (q_nc.size() == 0) check("nc_unexpected_valid", 32'd1, 32'd0);
      else check("nc_read", dout_nc, q_nc.pop_front());
    end
  end

  task automatic set_idle();
    writeOn = 1'b0; readOn = 1'b0; address = '0; byteEn = '0; data_in = '0;
  endtask

  task automatic set_nc_idle();
    we2 = 1'b0; re2 = 1'b0; addr2 = '0; be2 = '0; din2 = '0;
  endtask

  // One request cycle on the shared port; expectations are queued when a read is issued.
  task automatic issue(input logic w, input logic r, input logic [4:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [31:0] e_rf, input logic [31:0] e_wf);
    writeOn = w; readOn = r; address = a; byteEn = be; data_in = d;
    if (r) begin
      q_rf.push_back(e_rf);
      q_wf.push_back(e_wf);
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (busy_rf && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;

  initial begin
    set_idle();
    set_nc_idle();
    reset = 1'b1;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout_rf", dout_rf, 32'h0);
    check("reset_valid_rf", {31'd0, dv_rf}, 32'd0);
    check("reset_busy_rf", {31'd0, busy_rf}, 32'd1);
    check("reset_busy_wf", {31'd0, busy_wf}, 32'd1);
    check("reset_busy_nc", {31'd0, busy_nc}, 32'd0);
    reset = 1'b0;
    reset2 = 1'b0;

    // Clear phase on the clearing instances; a blocked request lands on clear cycle 10.
    // Meanwhile the no-clear instance works from its first cycle.
    n = 0;
    check("nc_busy_after_reset", {31'd0, busy_nc}, 32'd0);
    while (busy_rf && n < 100) begin
      if (n == 10) begin
        writeOn = 1'b1; readOn = 1'b1; address = 5'd3; byteEn = 4'hF; data_in = 32'hFFFF_FFFF;
      end else begin
        set_idle();
      end
      set_nc_idle();
      if (n == 0) begin
        we2 = 1'b1; addr2 = 5'd0; be2 = 4'hF; din2 = 32'h1234_5678;
      end else if (n == 1) begin
        re2 = 1'b1; addr2 = 5'd0; q_nc.push_back(32'h1234_5678);
      end else if (n == 2) begin
        we2 = 1'b1; re2 = 1'b1; addr2 = 5'd0; be2 = 4'b1100; din2 = 32'hFFFF_0000;
        q_nc.push_back(32'h1234_5678);
      end else if (n == 3) begin
        re2 = 1'b1; addr2 = 5'd0; q_nc.push_back(32'hFFFF_5678);
      end
      @(posedge clk); #1;
      n++;
    end
    set_idle();
    set_nc_idle();
    check("clear_cycles", n, 32);
    check("clear_busy_wf", {31'd0, busy_wf}, 32'd0);

    issue(0, 1, 5'd0,  4'h0, 32'h0, 32'h0, 32'h0);
    issue(0, 1, 5'd17, 4'h0, 32'h0, 32'h0, 32'h0);
    issue(0, 1, 5'd31, 4'h0, 32'h0, 32'h0, 32'h0);
    issue(0, 1, 5'd3,  4'h0, 32'h0, 32'h0, 32'h0);

    issue(1, 0, 5'd5, 4'b1111, 32'hDEAD_BEEF, 32'h0, 32'h0);
    issue(0, 1, 5'd5, 4'b0000, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue(1, 0, 5'd5, 4'b0101, 32'h1122_3344, 32'h0, 32'h0);
    issue(0, 1, 5'd5, 4'b0000, 32'h0, 32'hDE22_BE44, 32'hDE22_BE44);
    issue(1, 0, 5'd5, 4'b0000, 32'h9999_9999, 32'h0, 32'h0);
    issue(0, 1, 5'd5, 4'b0000, 32'h0, 32'hDE22_BE44, 32'hDE22_BE44);

    issue(1, 0, 5'd9, 4'b1111, 32'hAAAA_AAAA, 32'h0, 32'h0);
    issue(1, 1, 5'd9, 4'b1111, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555);
    issue(0, 1, 5'd9, 4'b0000, 32'h0, 32'h5555_5555, 32'h5555_5555);
    issue(1, 1, 5'd9, 4'b0011, 32'h0000_1234, 32'h5555_5555, 32'h5555_1234);
    issue(0, 1, 5'd9, 4'b0000, 32'h0, 32'h5555_1234, 32'h5555_1234);

    issue(1, 0, 5'd31, 4'b1111, 32'hCAFE_F00D, 32'h0, 32'h0);
    issue(0, 1, 5'd31, 4'b0000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset mid-clear must restart the full sweep.
    reset = 1'b1;
    #1;
    check("async_reset_dout", dout_rf, 32'h0);
    check("async_reset_busy", {31'd0, busy_rf}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midclear_busy", {31'd0, busy_rf}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    count_clear(n);
    check("midclear_cycles", n, 32);
    issue(0, 1, 5'd31, 4'h0, 32'h0, 32'h0, 32'h0);
    issue(0, 1, 5'd5,  4'h0, 32'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    check("rf_queue_drained", q_rf.size(), 32'd0);
    check("wf_queue_drained", q_wf.size(), 32'd0);
    check("nc_queue_drained", q_nc.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_sync_param.md
Name: ram_sync_param

Overview:
- Parametrised synchronous single-port RAM; next generation of the team's fixed 32x32 `ram_sync`.
- Adds generic width and depth, per-byte write enables, and an explicit read strobe with a registered, valid-flagged output.
- Adds selectable read-during-write mode and a hardware clear sequencer that zeroes the array after reset.
- Serves as the data/instruction memory for the team's datapath experiments and benches.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH words.
- READ_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset via the clear sequencer; 0 = array contents undefined, block ready immediately.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- writeOn  in  1  write request, sampled on clk.
- readOn  in  1  read request, sampled on clk.
- address  in  ADDR_WIDTH  word address for read and write.
- byteEn  in  DATA_WIDTH/8  per-byte write enable; bit k gates data_in[8k+7:8k].
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- dataValid  out  1  one-cycle pulse; data_out holds fresh read data.
- busy  out  1  high while the clear sequence runs; requests are ignored.

Behaviour:
- Reset (async assert): data_out=0, dataValid=0, clear counter=0.
  - CLEAR_ON_RESET=1: state=CLEAR, busy=1.
  - CLEAR_ON_RESET=0: state=IDLE, busy=0.
  - The array itself is not asynchronously reset.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes all-zeros to mem[counter], then counter+1.
  - When counter reaches 2**ADDR_WIDTH-1, that word is written and the next state is IDLE; busy drops the following cycle.
  - Clear duration is exactly 2**ADDR_WIDTH cycles after reset deassertion.
- Reset asserted mid-clear restarts the sequence from address 0.
- The counter is ADDR_WIDTH+1 bits wide so no wrap occurs before termination.
- While busy=1:
  - writeOn and readOn are ignored; no array write from the ports.
  - dataValid stays 0 and data_out holds its value.
- Write (IDLE, writeOn=1):
  - At the clock edge, for each k with byteEn[k]=1, mem[address] byte k <= data_in byte k. Other bytes are unchanged.
  - byteEn all zero means no change.
- Read (IDLE, readOn=1):
  - At edge N, data_out <= mem[address] and dataValid=1 during cycle N+1. Latency is 1 cycle.
  - Back-to-back reads give back-to-back valid pulses.
  - Without readOn, data_out holds its last value and dataValid=0.
- Simultaneous readOn and writeOn, same address:
  - READ_MODE=0: data_out = pre-write word.
  - READ_MODE=1: data_out = post-write word (old bytes merged with enabled new bytes).
  - The write is always performed.
- Address is ADDR_WIDTH bits wide, so out-of-range addresses cannot occur and no wrap handling is needed.
- No X on outputs after reset in any mode.

Decomposition:
- Shared package `ram_pkg`:
  - State encoding constants RAM_IDLE and RAM_CLEAR.
  - READ_FIRST=0 and WRITE_FIRST=1.
  - Helper function for byte-lane count (DATA_WIDTH/8).
- Sub-module `ram_clear_seq`: contains the counter and FSM. Outputs busy, clear write enable and clear address.
- The top level muxes the clear path against the port path into the array write.

Test Plan:
- Reset, defaults (CLEAR_ON_RESET=1, ADDR_WIDTH=5): assert reset 2 cycles then release → busy=1 for exactly 32 cycles. Then read addresses 0, 17 and 31 → data_out=0x00000000, dataValid pulses 1 cycle after each readOn.
- Full write then read: write 0xDEADBEEF with byteEn=4'b1111 at address 5, then readOn at 5 → next cycle data_out=0xDEADBEEF, dataValid=1.
- Byte enables: over 0xDEADBEEF at address 5, write 0x11223344 with byteEn=4'b0101 → read returns 0xDE22BE44. A write with byteEn=4'b0000 leaves the word unchanged.
- Read-during-write: address 9 holds 0xAAAAAAAA; same-cycle write 0x55555555 (all bytes) plus read.
  - READ_MODE=0 → data_out=0xAAAAAAAA.
  - READ_MODE=1 → data_out=0x55555555.
  - A following read returns 0x55555555 in both modes.
- Requests while busy: writeOn and readOn at address 3 during clear cycle 10 → no dataValid. After clear, address 3 reads 0.
- Reset mid-clear: assert reset at clear cycle 20 → busy stays 1 and a full 32 cycles elapse after release. Previously written data at address 31 reads 0 afterwards.
- CLEAR_ON_RESET=0: busy=0 immediately after reset, and a write/read at address 0 works in the first cycle after reset.
